// File: rtl/lsu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_unit
//  Description : Load/store unit. Accepts one request at a time, issues
//                XLEN-wide aligned memory transactions (split in two when a
//                misaligned access crosses a word and splitting is enabled),
//                merges and extends load data, and reports faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_misaligned,
  output logic                resp_access_fault,
  output logic                resp_illegal,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read_enable,
  input  logic                mem_read_valid,
  input  logic [XLEN-1:0]     mem_read_data,
  output logic                mem_write_enable,
  output logic [XLEN/8-1:0]   mem_write_wstrb,
  output logic [XLEN-1:0]     mem_write_data,
  input  logic                mem_write_ready,
  input  logic                mem_error
);

  localparam int c_w  = XLEN / 8;
  localparam int c_ow = $clog2(c_w);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic                  r_unsigned;
  logic [1:0]            r_size;
  logic [ADDR_W-1:0]     r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic [XLEN-1:0]       r_data0;
  logic [XLEN-1:0]       r_data1;
  logic                  r_mis;
  logic                  r_fault;
  logic                  r_ill;

  logic                  w_accept;
  logic                  w_req_ill;
  logic                  w_req_mis;
  logic [c_ow-1:0]       w_off;
  logic [c_w-1:0]        w_bmask;
  logic [2*c_w-1:0]      w_strb2;
  logic [2*XLEN-1:0]     w_data2;
  logic                  w_split;
  logic [ADDR_W-1:0]     w_base;
  logic                  w_done;
  logic [2*XLEN-1:0]     w_merge;
  logic [XLEN-1:0]       w_lo;
  logic [XLEN-1:0]       w_bits;
  logic                  w_sign;
  logic [XLEN-1:0]       w_ext;

  // Request decode: size legality and natural-alignment check at acceptance
  always_comb begin
    w_accept  = req_valid && (r_state == IDLE);
    w_req_ill = (req_size == 2'd3) && (XLEN == 32);
    case (req_size)
      2'd1:    w_req_mis = req_addr[0];
      2'd2:    w_req_mis = |req_addr[1:0];
      2'd3:    w_req_mis = |req_addr[2:0];
      default: w_req_mis = 1'b0;
    endcase
    w_req_mis = w_req_mis && (ALLOW_MISALIGNED == 0);
  end

  // Lane placement: the access is laid over a double-width window so the low
  // half feeds the first transaction and the high half the second one
  always_comb begin
    w_off = r_addr[c_ow-1:0];
    case (r_size)
      2'd0:    w_bmask = c_w'(1);
      2'd1:    w_bmask = c_w'(3);
      2'd2:    w_bmask = c_w'(15);
      default: w_bmask = '1;
    endcase
    w_strb2 = {{c_w{1'b0}}, w_bmask} << w_off;
    w_data2 = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
    w_split = |w_strb2[2*c_w-1:c_w];
    w_base  = {r_addr[ADDR_W-1:c_ow], {c_ow{1'b0}}};
    w_done  = r_write ? mem_write_ready : mem_read_valid;
  end

  // Load data merge (low transaction first), then sign/zero extension
  always_comb begin
    w_merge = {r_data1, r_data0} >> {w_off, 3'b000};
    w_lo    = w_merge[XLEN-1:0];
    w_bits  = '0;
    for (int i = 0; i < c_w; i++) begin
      w_bits[8*i +: 8] = {8{w_bmask[i]}};
    end
    case (r_size)
      2'd0:    w_sign = w_lo[7];
      2'd1:    w_sign = w_lo[15];
      2'd2:    w_sign = w_lo[31];
      default: w_sign = w_lo[XLEN-1];
    endcase
    w_sign = w_sign && !r_unsigned;
    w_ext  = (w_lo & w_bits) | ({XLEN{w_sign}} & ~w_bits);
  end

  // Next-state logic and all state-derived outputs
  always_comb begin
    w_next            = r_state;
    req_ready         = 1'b0;
    busy              = 1'b1;
    mem_address       = '0;
    mem_read_enable   = 1'b0;
    mem_write_enable  = 1'b0;
    mem_write_wstrb   = '0;
    mem_write_data    = '0;
    resp_valid        = 1'b0;
    resp_rdata        = '0;
    resp_misaligned   = 1'b0;
    resp_access_fault = 1'b0;
    resp_illegal      = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_next = (w_req_ill || w_req_mis) ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_address      = w_base;
        mem_read_enable  = !r_write;
        mem_write_enable = r_write;
        if (r_write) begin
          mem_write_wstrb = w_strb2[c_w-1:0];
          mem_write_data  = w_data2[XLEN-1:0];
        end
        if (w_done) begin
          w_next = (mem_error || !w_split) ? RESP : ACC1;
        end
      end
      ACC1: begin
        mem_address      = w_base + ADDR_W'(c_w);
        mem_read_enable  = !r_write;
        mem_write_enable = r_write;
        if (r_write) begin
          mem_write_wstrb = w_strb2[2*c_w-1:c_w];
          mem_write_data  = w_data2[2*XLEN-1:XLEN];
        end
        if (w_done) begin
          w_next = RESP;
        end
      end
      default: begin
        w_next            = IDLE;
        resp_valid        = 1'b1;
        resp_misaligned   = r_mis;
        resp_access_fault = r_fault;
        resp_illegal      = r_ill;
        if (!r_write && !r_mis && !r_fault && !r_ill) begin
          resp_rdata = w_ext;
        end
      end
    endcase
  end

  // State register, request capture and transaction results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_data0    <= '0;
      r_data1    <= '0;
      r_mis      <= 1'b0;
      r_fault    <= 1'b0;
      r_ill      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write    <= req_write;
        r_unsigned <= req_unsigned;
        r_size     <= req_size;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_data0    <= '0;
        r_data1    <= '0;
        r_ill      <= w_req_ill;
        r_mis      <= w_req_mis && !w_req_ill;
        r_fault    <= 1'b0;
      end
      if ((r_state == ACC0 || r_state == ACC1) && w_done) begin
        if (!r_write) begin
          if (r_state == ACC0) r_data0 <= mem_read_data;
          else                 r_data1 <= mem_read_data;
        end
        if (mem_error) r_fault <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_unit
//  Description : Self-checking bench for lsu_unit. Three instances cover
//                XLEN=32 trapping, XLEN=32 splitting and XLEN=64 splitting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // shared request stimulus, routed to the selected instance
  int          cur = 0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic a_rv, b_rv, c_rv;
  always_comb begin
    a_rv = req_valid && (cur == 0);
    b_rv = req_valid && (cur == 1);
    c_rv = req_valid && (cur == 2);
  end

  logic a_req_ready, a_resp_valid, a_mis, a_fault, a_ill, a_busy, a_rd_en, a_wr_en, a_rvalid, a_wready, a_err;
  logic [31:0] a_rdata, a_addr, a_wdata, a_rdat;
  logic [3:0]  a_strb;
  logic b_req_ready, b_resp_valid, b_mis, b_fault, b_ill, b_busy, b_rd_en, b_wr_en, b_rvalid, b_wready, b_err;
  logic [31:0] b_rdata, b_addr, b_wdata, b_rdat;
  logic [3:0]  b_strb;
  logic c_req_ready, c_resp_valid, c_mis, c_fault, c_ill, c_busy, c_rd_en, c_wr_en, c_rvalid, c_wready, c_err;
  logic [63:0] c_rdata, c_wdata, c_rdat;
  logic [31:0] c_addr;
  logic [7:0]  c_strb;

  lsu_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) u_a (
    .clock(clock), .reset(reset), .req_valid(a_rv), .req_ready(a_req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(a_resp_valid), .resp_rdata(a_rdata), .resp_misaligned(a_mis), .resp_access_fault(a_fault),
    .resp_illegal(a_ill), .busy(a_busy), .mem_address(a_addr), .mem_read_enable(a_rd_en),
    .mem_read_valid(a_rvalid), .mem_read_data(a_rdat), .mem_write_enable(a_wr_en), .mem_write_wstrb(a_strb),
    .mem_write_data(a_wdata), .mem_write_ready(a_wready), .mem_error(a_err));

  lsu_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_b (
    .clock(clock), .reset(reset), .req_valid(b_rv), .req_ready(b_req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .resp_misaligned(b_mis), .resp_access_fault(b_fault),
    .resp_illegal(b_ill), .busy(b_busy), .mem_address(b_addr), .mem_read_enable(b_rd_en),
    .mem_read_valid(b_rvalid), .mem_read_data(b_rdat), .mem_write_enable(b_wr_en), .mem_write_wstrb(b_strb),
    .mem_write_data(b_wdata), .mem_write_ready(b_wready), .mem_error(b_err));

  lsu_unit #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_c (
    .clock(clock), .reset(reset), .req_valid(c_rv), .req_ready(c_req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(c_resp_valid), .resp_rdata(c_rdata), .resp_misaligned(c_mis), .resp_access_fault(c_fault),
    .resp_illegal(c_ill), .busy(c_busy), .mem_address(c_addr), .mem_read_enable(c_rd_en),
    .mem_read_valid(c_rvalid), .mem_read_data(c_rdat), .mem_write_enable(c_wr_en), .mem_write_wstrb(c_strb),
    .mem_write_data(c_wdata), .mem_write_ready(c_wready), .mem_error(c_err));

  // byte memory (64 bytes, address wraps), reads are combinational
  logic [7:0] mem [0:63];
  function automatic logic [63:0] rd_mem(input logic [31:0] base, input int nb);
    logic [63:0] r;
    logic [31:0] a;
    r = '0;
    for (int i = 0; i < nb; i++) begin
      a = base + 32'(i);
      r[8*i +: 8] = mem[a[5:0]];
    end
    return r;
  endfunction

  logic [63:0] t_a, t_b;
  always_comb begin
    t_a    = rd_mem(a_addr, 4);
    t_b    = rd_mem(b_addr, 4);
    a_rdat = t_a[31:0];
    b_rdat = t_b[31:0];
    c_rdat = rd_mem(c_addr, 8);
  end

  // handshake model: completion after wait_n stall cycles, optional error
  int          wait_n = 0;
  int          cnt = 0;
  int          err_en = 0;
  logic [31:0] err_addr = '0;
  logic        hs, any_en;
  always_comb begin
    any_en   = a_rd_en | a_wr_en | b_rd_en | b_wr_en | c_rd_en | c_wr_en;
    hs       = (cnt >= wait_n);
    a_rvalid = a_rd_en && hs;  a_wready = a_wr_en && hs;
    b_rvalid = b_rd_en && hs;  b_wready = b_wr_en && hs;
    c_rvalid = c_rd_en && hs;  c_wready = c_wr_en && hs;
    a_err    = (a_rd_en | a_wr_en) && (err_en != 0) && (a_addr == err_addr);
    b_err    = (b_rd_en | b_wr_en) && (err_en != 0) && (b_addr == err_addr);
    c_err    = (c_rd_en | c_wr_en) && (err_en != 0) && (c_addr == err_addr);
  end
  always @(posedge clock) begin
    if (any_en && !hs) cnt <= cnt + 1;
    else               cnt <= 0;
  end

  // completed-transaction log
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [63:0] data;
  } txn_t;
  txn_t log_q[$];
  int   resp_cnt = 0;
  always @(posedge clock) begin
    if ((a_rd_en && a_rvalid) || (a_wr_en && a_wready)) log_q.push_back('{a_addr, {4'h0, a_strb}, {32'h0, a_wdata}});
    if ((b_rd_en && b_rvalid) || (b_wr_en && b_wready)) log_q.push_back('{b_addr, {4'h0, b_strb}, {32'h0, b_wdata}});
    if ((c_rd_en && c_rvalid) || (c_wr_en && c_wready)) log_q.push_back('{c_addr, c_strb, c_wdata});
    if (a_resp_valid || b_resp_valid || c_resp_valid) resp_cnt++;
  end

  // enables never together and never while idle
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if ((a_rd_en && a_wr_en) || ((a_rd_en || a_wr_en) && !a_busy) ||
          (b_rd_en && b_wr_en) || ((b_rd_en || b_wr_en) && !b_busy) ||
          (c_rd_en && c_wr_en) || ((c_rd_en || c_wr_en) && !c_busy)) begin
        errors++;
        $display("FAIL enable_rule: a rd/wr/busy=%b%b%b b=%b%b%b c=%b%b%b", a_rd_en, a_wr_en, a_busy,
                 b_rd_en, b_wr_en, b_busy, c_rd_en, c_wr_en, c_busy);
      end
    end
  end

  // selected instance view
  logic s_ready, s_rv, s_mis, s_fault, s_ill, s_busy;
  logic [63:0] s_rdata;
  always_comb begin
    s_ready = a_req_ready; s_rv = a_resp_valid; s_rdata = {32'h0, a_rdata};
    s_mis = a_mis; s_fault = a_fault; s_ill = a_ill; s_busy = a_busy;
    if (cur == 1) begin
      s_ready = b_req_ready; s_rv = b_resp_valid; s_rdata = {32'h0, b_rdata};
      s_mis = b_mis; s_fault = b_fault; s_ill = b_ill; s_busy = b_busy;
    end else if (cur == 2) begin
      s_ready = c_req_ready; s_rv = c_resp_valid; s_rdata = c_rdata;
      s_mis = c_mis; s_fault = c_fault; s_ill = c_ill; s_busy = c_busy;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int inst, wr, size, uns;
    logic [31:0] addr;
    logic [63:0] wdata;
    int waits, err;
    logic [63:0] rdata;
    int mis, fault, ill, lat, ntx;
    logic [31:0] a0; logic [7:0] s0; logic [63:0] d0;
    logic [31:0] a1; logic [7:0] s1; logic [63:0] d1;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input int inst, wr, size, uns, input logic [31:0] addr, input logic [63:0] wdata,
                              input int waits, err, input logic [63:0] rdata, input int mis, fault, ill, lat, ntx,
                              input logic [31:0] a0, input logic [7:0] s0, input logic [63:0] d0,
                              input logic [31:0] a1, input logic [7:0] s1, input logic [63:0] d1);
    vec_t v;
    v = '{inst, wr, size, uns, addr, wdata, waits, err, rdata, mis, fault, ill, lat, ntx, a0, s0, d0, a1, s1, d1};
    vq.push_back(v);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit seen;
    cur = v.inst; wait_n = v.waits; err_en = v.err; err_addr = v.a0;
    req_write = v.wr[0]; req_size = 2'(v.size); req_unsigned = v.uns[0];
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clock);
    log_q.delete();
    chk($sformatf("v%0d_ready", idx), 64'(s_ready), 64'd1);
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 30) begin
      @(negedge clock);
      lat++;
      if (s_rv) seen = 1;
    end
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d_rdata", idx), s_rdata, v.rdata);
    chk($sformatf("v%0d_flags", idx), {61'h0, s_mis, s_fault, s_ill}, {61'h0, v.mis[0], v.fault[0], v.ill[0]});
    chk($sformatf("v%0d_ntx", idx), 64'(log_q.size()), 64'(v.ntx));
    if (v.ntx >= 1 && log_q.size() >= 1) begin
      chk($sformatf("v%0d_addr0", idx), 64'(log_q[0].addr), 64'(v.a0));
      if (v.wr != 0) begin
        chk($sformatf("v%0d_strb0", idx), 64'(log_q[0].strb), 64'(v.s0));
        chk($sformatf("v%0d_data0", idx), log_q[0].data, v.d0);
      end
    end
    if (v.ntx >= 2 && log_q.size() >= 2) begin
      chk($sformatf("v%0d_addr1", idx), 64'(log_q[1].addr), 64'(v.a1));
      if (v.wr != 0) begin
        chk($sformatf("v%0d_strb1", idx), 64'(log_q[1].strb), 64'(v.s1));
        chk($sformatf("v%0d_data1", idx), log_q[1].data, v.d1);
      end
    end
    @(negedge clock);
    chk($sformatf("v%0d_post", idx), {61'h0, s_rv, s_ready, s_busy}, {61'h0, 1'b0, 1'b1, 1'b0});
    err_en = 0; wait_n = 0;
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0] = 8'h33; mem[1] = 8'h22; mem[2] = 8'h11; mem[3] = 8'h80;
    for (int i = 0; i < 7; i++) mem[8 + i] = 8'(i + 1);
    mem[15] = 8'h88;
    mem[16'h13] = 8'hAA;
    mem[16'h14] = 8'hDD; mem[16'h15] = 8'hBB; mem[16'h16] = 8'hCC;
    mem[16'h3E] = 8'h77; mem[16'h3F] = 8'h66;

    //   inst wr sz un addr           wdata                  wt er rdata                  mi fa il lat ntx a0            s0     d0                     a1            s1     d1
    add(0, 0, 0, 0, 32'h80000003, 64'h0, 0, 0, 64'hFFFFFF80, 0, 0, 0, 2, 1, 32'h80000000, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(0, 0, 0, 1, 32'h80000003, 64'h0, 0, 0, 64'h00000080, 0, 0, 0, 2, 1, 32'h80000000, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(0, 0, 1, 0, 32'h80000000, 64'h0, 0, 0, 64'h00002233, 0, 0, 0, 2, 1, 32'h80000000, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(0, 0, 1, 0, 32'h80000002, 64'h0, 0, 0, 64'hFFFF8011, 0, 0, 0, 2, 1, 32'h80000000, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(0, 0, 2, 0, 32'h80000000, 64'h0, 0, 0, 64'h80112233, 0, 0, 0, 2, 1, 32'h80000000, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(0, 1, 1, 0, 32'h80000002, 64'hBEEF, 0, 0, 64'h0, 0, 0, 0, 2, 1, 32'h80000000, 8'h0C, 64'hBEEF0000, 32'h0, 8'h00, 64'h0);
    add(0, 1, 0, 0, 32'h80000001, 64'hA5, 0, 0, 64'h0, 0, 0, 0, 2, 1, 32'h80000000, 8'h02, 64'h0000A500, 32'h0, 8'h00, 64'h0);
    add(0, 0, 2, 0, 32'h80000001, 64'h0, 0, 0, 64'h0, 1, 0, 0, 1, 0, 32'h0, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(0, 0, 1, 0, 32'h80000003, 64'h0, 0, 0, 64'h0, 1, 0, 0, 1, 0, 32'h0, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(0, 0, 3, 0, 32'h80000000, 64'h0, 0, 0, 64'h0, 0, 0, 1, 1, 0, 32'h0, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(0, 1, 2, 0, 32'h80000000, 64'h12345678, 0, 1, 64'h0, 0, 1, 0, 2, 1, 32'h80000000, 8'h0F, 64'h12345678, 32'h0, 8'h00, 64'h0);
    add(1, 0, 2, 0, 32'h80000013, 64'h0, 0, 0, 64'hCCBBDDAA, 0, 0, 0, 3, 2, 32'h80000010, 8'h00, 64'h0, 32'h80000014, 8'h00, 64'h0);
    add(1, 0, 1, 0, 32'h80000013, 64'h0, 0, 0, 64'hFFFFDDAA, 0, 0, 0, 3, 2, 32'h80000010, 8'h00, 64'h0, 32'h80000014, 8'h00, 64'h0);
    add(1, 0, 1, 0, 32'h80000015, 64'h0, 0, 0, 64'hFFFFCCBB, 0, 0, 0, 2, 1, 32'h80000014, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(1, 1, 2, 0, 32'h80000012, 64'h11223344, 0, 0, 64'h0, 0, 0, 0, 3, 2, 32'h80000010, 8'h0C, 64'h33440000, 32'h80000014, 8'h03, 64'h00001122);
    add(1, 0, 2, 0, 32'h80000013, 64'h0, 1, 0, 64'hCCBBDDAA, 0, 0, 0, 5, 2, 32'h80000010, 8'h00, 64'h0, 32'h80000014, 8'h00, 64'h0);
    add(1, 0, 2, 0, 32'h80000013, 64'h0, 0, 1, 64'h0, 0, 1, 0, 2, 1, 32'h80000010, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(1, 0, 2, 0, 32'hFFFFFFFE, 64'h0, 0, 0, 64'h22336677, 0, 0, 0, 3, 2, 32'hFFFFFFFC, 8'h00, 64'h0, 32'h00000000, 8'h00, 64'h0);
    add(2, 0, 3, 0, 32'h80000008, 64'h0, 0, 0, 64'h8807060504030201, 0, 0, 0, 2, 1, 32'h80000008, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(2, 0, 2, 0, 32'h8000000C, 64'h0, 0, 0, 64'hFFFFFFFF88070605, 0, 0, 0, 2, 1, 32'h80000008, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(2, 0, 2, 1, 32'h8000000C, 64'h0, 0, 0, 64'h0000000088070605, 0, 0, 0, 2, 1, 32'h80000008, 8'h00, 64'h0, 32'h0, 8'h00, 64'h0);
    add(2, 0, 3, 0, 32'h8000000C, 64'h0, 0, 0, 64'hAA00000088070605, 0, 0, 0, 3, 2, 32'h80000008, 8'h00, 64'h0, 32'h80000010, 8'h00, 64'h0);
    add(2, 1, 0, 0, 32'h8000000F, 64'h5A, 0, 0, 64'h0, 0, 0, 0, 2, 1, 32'h80000008, 8'h80, 64'h5A00000000000000, 32'h0, 8'h00, 64'h0);

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_a_ctrl", {58'h0, a_req_ready, a_resp_valid, a_busy, a_rd_en, a_wr_en, a_mis}, {58'h0, 6'b100000});
    chk("rst_a_addr", 64'(a_addr), 64'h0);
    chk("rst_a_wr", {28'h0, a_strb, a_wdata}, 64'h0);
    chk("rst_a_rdata", 64'(a_rdata), 64'h0);
    chk("rst_c_out", c_wdata | 64'(c_addr) | 64'(c_strb), 64'h0);
    reset = 1'b0;

    foreach (vq[i]) run_vec(vq[i], i);

    // XLEN=64 double store with three stall cycles: outputs held until ready
    cur = 2; wait_n = 3; err_en = 0;
    req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 32'h80000008; req_wdata = 64'h1122334455667788;
    @(negedge clock);
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk($sformatf("wait%0d_en", k), {62'h0, c_wr_en, c_rd_en}, {62'h0, 2'b10});
      chk($sformatf("wait%0d_addr", k), 64'(c_addr), 64'h80000008);
      chk($sformatf("wait%0d_strb", k), 64'(c_strb), 64'hFF);
      chk($sformatf("wait%0d_data", k), c_wdata, 64'h1122334455667788);
      chk($sformatf("wait%0d_ready_resp", k), {62'h0, c_wready, c_resp_valid}, {62'h0, (k == 4), 1'b0});
    end
    @(negedge clock);
    chk("wait_resp", {61'h0, c_resp_valid, c_fault, c_mis}, {61'h0, 3'b100});
    chk("wait_rdata", c_rdata, 64'h0);
    @(negedge clock);
    chk("wait_idle", {62'h0, c_resp_valid, c_req_ready}, {62'h0, 2'b01});
    wait_n = 0;

    // reset in the middle of ACC0 abandons the transaction
    cur = 0; wait_n = 8;
    req_write = 1'b0; req_size = 2'd2; req_addr = 32'h80000000;
    @(negedge clock);
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("abort_pre", {62'h0, a_rd_en, a_busy}, {62'h0, 2'b11});
    r0 = resp_cnt;
    #2 reset = 1'b1;
    #1;
    chk("abort_en", {61'h0, a_rd_en, a_wr_en, a_busy}, {61'h0, 3'b000});
    chk("abort_addr", 64'(a_addr), 64'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ready", 64'(a_req_ready), 64'd1);
    repeat (3) @(negedge clock);
    chk("abort_noresp", 64'(resp_cnt - r0), 64'd0);
    wait_n = 0;
    run_vec(vq[4], 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
Parametrised load/store unit that replaces the single-cycle memory-access path of the core. It accepts one load/store request at a time from the execute stage and issues XLEN-wide aligned read/write transactions with a valid/ready handshake. It optionally splits misaligned accesses into two transactions, then merges, sign- or zero-extends and returns the result. It reports misalignment and access faults to the trap logic.

Parameters:
XLEN, 32, data path width; legal values 32 or 64.
ADDR_W, 32, byte-address width.
ALLOW_MISALIGNED, 0, 1 = split word-crossing accesses into two transactions; 0 = trap them.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (double legal only when XLEN=64)
req_unsigned  in  1  zero-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, LSB-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and faults
resp_misaligned  out  1  misaligned fault (with resp_valid)
resp_access_fault  out  1  bus error (with resp_valid)
resp_illegal  out  1  illegal size (with resp_valid)
busy  out  1  state != IDLE; used as the core stall
mem_address  out  ADDR_W  XLEN/8-aligned transaction address
mem_read_enable  out  1  read request
mem_read_valid  in  1  read data valid
mem_read_data  in  XLEN  read data
mem_write_enable  out  1  write request
mem_write_wstrb  out  XLEN/8  byte strobes
mem_write_data  out  XLEN  lane-shifted write data
mem_write_ready  in  1  write accepted
mem_error  in  1  access error; sampled together with read_valid/write_ready

Behaviour:
- Reset (async): state = IDLE; resp_* = 0; mem_read_enable = mem_write_enable = 0; mem_address, mem_write_data, mem_write_wstrb = 0; captured request cleared. Reset mid-transaction abandons it: enables drop immediately and no response is issued.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE -> accept on req_valid & req_ready. Capture all request fields. Let B = 1 << req_size and W = XLEN/8. Decode in priority order:
  - Illegal size (size=3 with XLEN=32) -> RESP with resp_illegal.
  - addr % B != 0 and ALLOW_MISALIGNED=0 -> RESP with resp_misaligned.
  - Otherwise -> ACC0.
- split = (addr % W) + B > W. split can only occur with ALLOW_MISALIGNED=1.
- ACC0:
  - mem_address = addr & ~(W-1).
  - Strobes = the B-byte mask shifted by addr % W, truncated to W bits.
  - Write data = req_wdata << 8*(addr % W).
  - Enables and outputs are held stable until handshake completion at a clock edge, i.e. mem_read_valid or mem_write_ready is high.
  - Read data is captured at that edge.
  - On completion: mem_error -> RESP with resp_access_fault; split -> ACC1; else -> RESP.
- ACC1:
  - mem_address = ACC0 address + W, wrapping modulo 2^ADDR_W.
  - Carries the remaining upper bytes at lanes 0..: strobes and data shifted right by W - addr % W.
  - Same handshake as ACC0; an error sets resp_access_fault.
- RESP:
  - resp_valid high for exactly one cycle; next state is IDLE.
  - Load data: bytes merged low-first from ACC0 (and ACC1 if split), shifted to LSB, then sign-extended from bit 8B-1 unless req_unsigned.
  - Fault flags are mutually exclusive. On any fault, resp_rdata = 0 and no further transaction is issued.
  - No backpressure on the response.
- Latency: with zero-wait memory, an accepted request gives resp_valid 2 cycles after acceptance, or 3 if split. Each wait cycle adds 1. A decode fault gives resp_valid 1 cycle after acceptance.
- mem_read_enable and mem_write_enable are never asserted together, and never outside ACC0/ACC1.
- busy = (state != IDLE). A new request may be accepted in the cycle after RESP.

Test Plan:
- XLEN=32: load byte addr 0x8000_0003, memory word 0x80_11_22_33 -> mem_address 0x8000_0000; resp_rdata 0xFFFF_FF80 signed, 0x0000_0080 with req_unsigned.
- XLEN=32: store half 0xBEEF to 0x8000_0002 -> wstrb 4'b1100, write_data 0xBEEF_0000; resp_valid 2 cycles after accept with zero-wait memory.
- ALLOW_MISALIGNED=0: word load at 0x8000_0001 -> no mem enable asserted; resp_misaligned=1 one cycle after accept; resp_rdata=0.
- ALLOW_MISALIGNED=1, XLEN=32: word load at 0x8000_0003; word 0x8000_0000 = 0xAA00_0000, word 0x8000_0004 = 0x00CC_BBDD -> two reads; resp_rdata 0xCCBB_DDAA.
- XLEN=64: double store to 0x8000_0008 with 3 wait cycles on mem_write_ready -> wstrb 8'hFF; outputs stable for all waits; resp_valid 1 cycle after ready.
- mem_error on the first half of a split access -> no ACC1 transaction; resp_access_fault=1. Assert reset during ACC0 -> enables 0 immediately; no resp_valid; req_ready=1 once reset is released.
